nrs_tx_gen_mapper: RTL and testbench

//  Transmit-side NB-IoT NRS source, antenna port 2000, normal CP. Per subframe it produces 8 QPSK NRS symbols.

---
 rtl/nrs_tx_gen_mapper_pkg.sv | 43 ++++
 rtl/nrs_tx_gen_mapper_if.sv | 26 ++
 rtl/nrs_tx_cinit.sv | 30 +++
 rtl/nrs_tx_gen_mapper.sv | 163 ++++++++++++++++
 tb/tb_nrs_tx_gen_mapper.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nrs_tx_gen_mapper_pkg.sv
// nrs_tx_gen_mapper_pkg
//   Shared constants, FSM encoding and small helpers for the NB-IoT NRS
//   transmit generator (antenna port 2000, normal CP).
//   No ports; imported by nrs_tx_cinit and nrs_tx_gen_mapper.
package nrs_tx_gen_mapper_pkg;

  localparam int NC       = 1600;
  localparam int NMAX_RB  = 110;
  localparam int OFFS     = 2 * (NMAX_RB - 1);
  localparam int WIDTH_B  = 9;
  localparam int SKIP_LEN = NC + OFFS;

  localparam logic [2:0] NRS_L0 = 3'd5;
  localparam logic [2:0] NRS_L1 = 3'd6;

  // Register bit 0 holds x(n); the tap mask selects the terms XORed into x(n+31).
  localparam logic [30:0] X1_TAPS = 31'h0000_0009;
  localparam logic [30:0] X2_TAPS = 31'h0000_000F;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_LOAD = 3'd2,
    ST_SKIP = 3'd3,
    ST_CAPT = 3'd4,
    ST_EMIT = 3'd5
  } nrs_state_t;

  function automatic logic [30:0] lfsr_step(input logic [30:0] x, input logic [30:0] taps);
    return {^(x & taps), x[30:1]};
  endfunction

  // Base subcarrier (m=0): (v + N_cell_ID mod 6) mod 6, v=3 for l=6 else 0.
  function automatic logic [3:0] k_base(input logic [WIDTH_B-1:0] cell_id, input logic l_is_6);
    logic [2:0] rem;
    logic [3:0] sum;
    rem = 3'(cell_id % WIDTH_B'(6));
    sum = {1'b0, rem} + (l_is_6 ? 4'd3 : 4'd0);
    if (sum >= 4'd6) sum = sum - 4'd6;
    return sum;
  endfunction

endpackage

// File: rtl/nrs_tx_gen_mapper_if.sv
// nrs_tx_gen_mapper_if
//   Valid/ready NRS symbol stream towards the TX resource-grid mapper.
//   nrs_valid / nrs_ready : handshake
//   nrs_r, nrs_i          : QPSK sign bits (0 -> +1/sqrt2, 1 -> -1/sqrt2)
//   nrs_k                 : subcarrier 0..11
//   nrs_l                 : OFDM symbol 5 or 6
//   nrs_slot              : slot number 0..19
interface nrs_tx_gen_mapper_if;
  logic       nrs_valid;
  logic       nrs_ready;
  logic       nrs_r;
  logic       nrs_i;
  logic [3:0] nrs_k;
  logic [2:0] nrs_l;
  logic [4:0] nrs_slot;

  modport master (
    output nrs_valid, nrs_r, nrs_i, nrs_k, nrs_l, nrs_slot,
    input  nrs_ready
  );

  modport slave (
    input  nrs_valid, nrs_r, nrs_i, nrs_k, nrs_l, nrs_slot,
    output nrs_ready
  );
endinterface

// File: rtl/nrs_tx_cinit.sv
// nrs_tx_cinit
//   Combinational Gold-sequence initialiser for one NRS job:
//   cinit = ((7*(ns+1) + l + 1) * (2*N_cell_ID + 1)) << 10 + 2*N_cell_ID + 1
//   Ports:
//     ns      in  5   slot number 0..19
//     l       in  3   OFDM symbol (5 or 6)
//     cell_id in  9   physical cell id 0..503
//     cinit   out 28  initial value of x2
module nrs_tx_cinit
  import nrs_tx_gen_mapper_pkg::*;
(
  input  logic [4:0]         ns,
  input  logic [2:0]         l,
  input  logic [WIDTH_B-1:0] cell_id,
  output logic [27:0]        cinit
);

  logic [7:0]  slot_term;
  logic [9:0]  id_term;
  logic [17:0] prod;

  // Largest slot term is 7*20+7 = 147, so 8 bits suffice.
  assign slot_term = 8'd7 * ({3'b000, ns} + 8'd1) + {5'b00000, l} + 8'd1;
  assign id_term   = {cell_id, 1'b1};
  assign prod      = {10'b0, slot_term} * {8'b0, id_term};

  // The product is shifted by 10 and 2N+1 < 1024, so the add is a concatenation.
  assign cinit = {prod, id_term};

endmodule

// File: rtl/nrs_tx_gen_mapper.sv
// nrs_tx_gen_mapper
//   NB-IoT NRS source for the transmit path. Each subframe start launches
//   four jobs (ns=2sf,l=5), (2sf,6), (2sf+1,5), (2sf+1,6); each job seeds the
//   Gold sequence, fast-forwards NC+OFFS bits, captures four bits and emits
//   two QPSK symbols (m=0, m=1) on the valid/ready stream.
//   Ports:
//     clk          in   single clock
//     rst_n        in   asynchronous active-low reset
//     N_cell_ID    in   PCI, latched at each start
//     new_frame    in   pulse, forces subframe counter to 0
//     new_subframe in   pulse, starts generation for the next subframe
//     nrs          if   master side of the symbol stream
//     busy         out  generation in progress
//     gen_done     out  1-cycle pulse after the 8th handshake
//     overrun      out  1-cycle pulse when a start aborts a running subframe
module nrs_tx_gen_mapper
  import nrs_tx_gen_mapper_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH_B-1:0]   N_cell_ID,
  input  logic                 new_frame,
  input  logic                 new_subframe,
  nrs_tx_gen_mapper_if.master  nrs,
  output logic                 busy,
  output logic                 gen_done,
  output logic                 overrun
);

  nrs_state_t         state, state_nxt;
  logic               start;
  logic               handshake;
  logic               last_sym;
  logic               last_job;
  logic [3:0]         sf;
  logic [WIDTH_B-1:0] cell_id;
  logic [1:0]         job;
  logic               m;
  logic [27:0]        cinit_w, cinit_q;
  logic [30:0]        x1, x2;
  logic [10:0]        skip_cnt;
  logic [1:0]         capt_cnt;
  logic [3:0]         sym_bits;
  logic [4:0]         ns;
  logic [2:0]         l_cur;

  // new_frame always coincides with a subframe start, so either pulse starts a subframe.
  assign start     = new_subframe | new_frame;
  assign handshake = (state == ST_EMIT) & nrs.nrs_ready;
  assign last_sym  = handshake & m;
  assign last_job  = (job == 2'd3);
  assign ns        = {sf, job[1]};
  assign l_cur     = job[0] ? NRS_L1 : NRS_L0;

  nrs_tx_cinit u_cinit (
    .ns      (ns),
    .l       (l_cur),
    .cell_id (cell_id),
    .cinit   (cinit_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // A start in any state restarts from CALC; when busy this is the abort path.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ST_CALC;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_IDLE;
        ST_CALC: state_nxt = ST_LOAD;
        ST_LOAD: state_nxt = ST_SKIP;
        ST_SKIP: if (skip_cnt == 11'(SKIP_LEN - 1)) state_nxt = ST_CAPT;
        ST_CAPT: if (capt_cnt == 2'd3) state_nxt = ST_EMIT;
        ST_EMIT: if (last_sym) state_nxt = last_job ? ST_IDLE : ST_CALC;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Payload is forced to zero outside EMIT so idle/reset outputs are all 0.
  always_comb begin
    busy          = (state != ST_IDLE);
    nrs.nrs_valid = 1'b0;
    nrs.nrs_r     = 1'b0;
    nrs.nrs_i     = 1'b0;
    nrs.nrs_k     = 4'd0;
    nrs.nrs_l     = 3'd0;
    nrs.nrs_slot  = 5'd0;
    if (state == ST_EMIT) begin
      nrs.nrs_valid = 1'b1;
      nrs.nrs_r     = m ? sym_bits[2] : sym_bits[0];
      nrs.nrs_i     = m ? sym_bits[3] : sym_bits[1];
      nrs.nrs_k     = k_base(cell_id, job[0]) + (m ? 4'd6 : 4'd0);
      nrs.nrs_l     = l_cur;
      nrs.nrs_slot  = ns;
    end
  end

  // Datapath: subframe counter, job sequencing and the two Gold-sequence LFSRs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sf       <= 4'd0;
      cell_id  <= '0;
      job      <= 2'd0;
      m        <= 1'b0;
      cinit_q  <= 28'd0;
      x1       <= 31'd0;
      x2       <= 31'd0;
      skip_cnt <= 11'd0;
      capt_cnt <= 2'd0;
      sym_bits <= 4'd0;
      gen_done <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (start) begin
        cell_id <= N_cell_ID;
        job     <= 2'd0;
        m       <= 1'b0;
        if (new_frame)       sf <= 4'd0;
        else if (sf == 4'd9) sf <= 4'd0;
        else                 sf <= sf + 4'd1;
      end else begin
        case (state)
          ST_CALC: cinit_q <= cinit_w;
          ST_LOAD: begin
            x1       <= 31'h0000_0001;
            x2       <= {3'b000, cinit_q};
            skip_cnt <= 11'd0;
          end
          ST_SKIP: begin
            x1       <= lfsr_step(x1, X1_TAPS);
            x2       <= lfsr_step(x2, X2_TAPS);
            skip_cnt <= skip_cnt + 11'd1;
            capt_cnt <= 2'd0;
          end
          // Captured bits c(218..221) land in sym_bits[0..3] = r0,i0,r1,i1.
          ST_CAPT: begin
            sym_bits[capt_cnt] <= x1[0] ^ x2[0];
            x1       <= lfsr_step(x1, X1_TAPS);
            x2       <= lfsr_step(x2, X2_TAPS);
            capt_cnt <= capt_cnt + 2'd1;
            m        <= 1'b0;
          end
          ST_EMIT: begin
            if (handshake) begin
              m <= ~m;
              if (m) job <= job + 2'd1;
            end
          end
          default: ;
        endcase
      end
      gen_done <= ~start & last_sym & last_job;
      overrun  <= start & (state != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_nrs_tx_gen_mapper.sv
// tb_nrs_tx_gen_mapper
//   Directed bench for nrs_tx_gen_mapper with a scoreboard queue of expected
//   symbols built from an independent Gold-sequence model.
module tb_nrs_tx_gen_mapper;

  // Edges from the edge that samples new_subframe until valid is visible,
  // i.e. valid appears in cycle 1825 counting the pulse cycle as cycle 0.
  localparam int LAT_FIRST  = 1824;
  localparam int WAIT_BOUND = 4000;

  typedef struct packed {
    logic       r;
    logic       i;
    logic [3:0] k;
    logic [2:0] l;
    logic [4:0] slot;
  } sym_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] N_cell_ID;
  logic       new_frame;
  logic       new_subframe;
  logic       busy;
  logic       gen_done;
  logic       overrun;

  nrs_tx_gen_mapper_if bus ();

  nrs_tx_gen_mapper dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .N_cell_ID    (N_cell_ID),
    .new_frame    (new_frame),
    .new_subframe (new_subframe),
    .nrs          (bus),
    .busy         (busy),
    .gen_done     (gen_done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  sym_t expQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;
  int   hsCount = 0;
  int   doneCount = 0;
  int   modelSf = 0;
  logic prevHeld = 1'b0;
  sym_t heldSym;
  sym_t curSym;

  assign curSym = {bus.nrs_r, bus.nrs_i, bus.nrs_k, bus.nrs_l, bus.nrs_slot};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    testsRun++;
    assert (obs === expv) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference Gold sequence: x1/x2 built as plain arrays, bits c(218..221).
  function automatic logic [3:0] goldBits(input logic [27:0] cinit);
    bit x1[0:1852];
    bit x2[0:1852];
    logic [3:0] res;
    for (int n = 0; n < 31; n++) begin
      x1[n] = (n == 0);
      x2[n] = (n < 28) ? cinit[n] : 1'b0;
    end
    for (int n = 0; n + 31 <= 1821; n++) begin
      x1[n+31] = x1[n+3] ^ x1[n];
      x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
    end
    for (int q = 0; q < 4; q++) res[q] = x1[1600+218+q] ^ x2[1600+218+q];
    return res;
  endfunction

  task automatic pushSubframe(input int sf, input int pci);
    for (int j = 0; j < 4; j++) begin
      int ns, l, v, a, b;
      logic [27:0] cinit;
      logic [3:0]  bits;
      ns    = 2 * sf + j / 2;
      l     = (j % 2 == 1) ? 6 : 5;
      v     = (l == 6) ? 3 : 0;
      a     = 7 * (ns + 1) + l + 1;
      b     = 2 * pci + 1;
      cinit = 28'(a * b * 1024 + b);
      bits  = goldBits(cinit);
      for (int mm = 0; mm < 2; mm++) begin
        sym_t s;
        s.r    = bits[2*mm];
        s.i    = bits[2*mm+1];
        s.k    = 4'(6 * mm + ((v + pci % 6) % 6));
        s.l    = 3'(l);
        s.slot = 5'(ns);
        expQ.push_back(s);
      end
    end
  endtask

  // Called #1 after a posedge; returns #1 after the edge that samples the start.
  task automatic applyStimulus(input bit frame, input int pci, input bit push);
    N_cell_ID    = 9'(pci);
    new_frame    = frame;
    new_subframe = 1'b1;
    modelSf      = frame ? 0 : ((modelSf == 9) ? 0 : modelSf + 1);
    if (push) pushSubframe(modelSf, pci);
    @(posedge clk); #1;
    new_frame    = 1'b0;
    new_subframe = 1'b0;
    N_cell_ID    = 9'($urandom_range(0, 503));
  endtask

  task automatic waitValid(output int cyc);
    cyc = 0;
    while (!bus.nrs_valid && cyc < WAIT_BOUND) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic waitDone(input bit randReady, output bit seen);
    int cyc;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 5 * WAIT_BOUND) begin
      if (randReady) bus.nrs_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
      seen = gen_done;
    end
  endtask

  // Handshake scoreboard and hold-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prevHeld = 1'b0;
    end else begin
      if (gen_done) doneCount++;
      if (prevHeld) begin
        checkOutput("hold_valid", 32'(bus.nrs_valid), 32'd1);
        checkOutput("hold_payload", 32'(curSym), 32'(heldSym));
      end
      if (bus.nrs_valid && bus.nrs_ready) begin
        hsCount++;
        checkOutput("sb_pending", 32'(expQ.size() != 0), 32'd1);
        if (expQ.size() != 0) begin
          sym_t e;
          e = expQ.pop_front();
          checkOutput("sym_r", 32'(bus.nrs_r), 32'(e.r));
          checkOutput("sym_i", 32'(bus.nrs_i), 32'(e.i));
          checkOutput("sym_k", 32'(bus.nrs_k), 32'(e.k));
          checkOutput("sym_l", 32'(bus.nrs_l), 32'(e.l));
          checkOutput("sym_slot", 32'(bus.nrs_slot), 32'(e.slot));
        end
      end
      prevHeld = bus.nrs_valid && !bus.nrs_ready && !new_subframe && !new_frame;
      heldSym  = curSym;
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog simulation time exhausted");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  cyc;
    bit  seen;
    int  doneSnap;

    rst_n         = 1'b0;
    N_cell_ID     = 9'd0;
    new_frame     = 1'b0;
    new_subframe  = 1'b0;
    bus.nrs_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(bus.nrs_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_gen_done", 32'(gen_done), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    checkOutput("rst_payload", 32'(curSym), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Subframe 0, PCI 0, ready held high.
    hsCount = 0;
    applyStimulus(1'b1, 0, 1'b1);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    waitValid(cyc);
    checkOutput("t1_latency", 32'(cyc), 32'(LAT_FIRST));
    waitDone(1'b0, seen);
    checkOutput("t1_gen_done", 32'(seen), 32'd1);
    checkOutput("t1_busy_end", 32'(busy), 32'd0);
    checkOutput("t1_sb_empty", 32'(expQ.size()), 32'd0);

    // Start issued in the gen_done cycle: normal start, no overrun.
    applyStimulus(1'b0, 1, 1'b1);
    checkOutput("t2_hs_count_prev", 32'(hsCount), 32'd8);
    checkOutput("t2_no_overrun", 32'(overrun), 32'd0);
    checkOutput("t2_gen_done_pulse", 32'(gen_done), 32'd0);
    hsCount = 0;
    waitDone(1'b0, seen);
    checkOutput("t2_gen_done", 32'(seen), 32'd1);
    checkOutput("t2_sb_empty", 32'(expQ.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t2_hs_count", 32'(hsCount), 32'd8);

    // PCI 7 with random back-pressure.
    hsCount   = 0;
    doneCount = 0;
    applyStimulus(1'b0, 7, 1'b1);
    waitDone(1'b1, seen);
    bus.nrs_ready = 1'b1;
    checkOutput("t3_gen_done", 32'(seen), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t3_hs_count", 32'(hsCount), 32'd8);
    checkOutput("t3_done_count", 32'(doneCount), 32'd1);
    checkOutput("t3_sb_empty", 32'(expQ.size()), 32'd0);

    // Walk ten subframes with ready low; each restart aborts the previous one.
    bus.nrs_ready = 1'b0;
    for (int p = 0; p < 10; p++) begin
      applyStimulus(1'b0, 11, 1'b0);
      checkOutput("t4_overrun", 32'(overrun), 32'(p != 0));
      waitValid(cyc);
      checkOutput("t4_latency", 32'(cyc), 32'(LAT_FIRST));
      checkOutput("t4_slot", 32'(bus.nrs_slot), 32'(2 * modelSf));
      checkOutput("t4_l", 32'(bus.nrs_l), 32'd5);
      checkOutput("t4_k", 32'(bus.nrs_k), 32'(11 % 6));
    end

    // Abort in the middle of the fast-forward phase.
    applyStimulus(1'b0, 20, 1'b0);
    checkOutput("t5_overrun_emit", 32'(overrun), 32'd1);
    repeat (902) @(posedge clk);
    #1;
    checkOutput("t5_busy_skip", 32'(busy), 32'd1);
    applyStimulus(1'b0, 20, 1'b0);
    checkOutput("t5_overrun", 32'(overrun), 32'd1);
    @(posedge clk); #1;
    checkOutput("t5_overrun_pulse", 32'(overrun), 32'd0);
    waitValid(cyc);
    checkOutput("t5_latency", 32'(cyc + 1), 32'(LAT_FIRST));
    checkOutput("t5_slot", 32'(bus.nrs_slot), 32'(2 * modelSf));
    checkOutput("t5_k", 32'(bus.nrs_k), 32'(20 % 6));

    // Reset while a symbol is being offered.
    doneSnap = doneCount;
    checkOutput("t6_valid_before", 32'(bus.nrs_valid), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("t6_valid", 32'(bus.nrs_valid), 32'd0);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_gen_done", 32'(gen_done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    modelSf = 0;
    @(posedge clk); #1;
    applyStimulus(1'b0, 3, 1'b0);
    checkOutput("t6_no_overrun", 32'(overrun), 32'd0);
    waitValid(cyc);
    checkOutput("t6_latency", 32'(cyc), 32'(LAT_FIRST));
    checkOutput("t6_slot_after_rst", 32'(bus.nrs_slot), 32'd2);
    checkOutput("t6_k", 32'(bus.nrs_k), 32'd3);
    checkOutput("t6_no_done", 32'(doneCount), 32'(doneSnap));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
